// File: rtl/sram_mem_controller_pkg.sv
// Purpose: shared types and constants for the MEM-stage SRAM controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_mem_controller_pkg;

    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;
    localparam logic [31:0] DEFAULT_DATA_BASE = 32'd1024;
    // Wide enough for WAIT_CYCLES up to 15.
    localparam int          CNT_W             = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sram_mem_controller_phase_counter.sv
// Purpose: counts clocks within one half-word SRAM phase and flags the final one.
// Latency: last_o is combinational from the count register.
// Backpressure: none; counts while en_i is high and wraps to 0 after the last count.
// Ports: clk/rst (sync, active-low); clear_i forces 0; en_i advances; last_o at WAIT_CYCLES-1.
module sram_phase_counter
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            // Wrap at the end of a phase so the next phase starts from 0.
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_mem_controller.sv
// Purpose: moves one 32-bit MEM-stage access as two 16-bit SRAM cycles, low half first.
// Latency: request seen in IDLE at cycle 0 -> ready=1 in cycle 1+2*WAIT_CYCLES.
// Backpressure: ready=0 while a transfer runs; the pipeline freezes on ~ready.
// Ports: clk, rst (sync, active-low); rd_en/wr_en/address/write_data from EXE/MEM;
//        read_data/ready to MEM/WB and hazard logic; SRAM_* to the external 16-bit SRAM.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    state_e      state_q;
    state_e      state_d;
    logic        is_wr_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        req;
    logic        in_xfer;
    logic        is_hi;
    logic        phase_last;
    logic [16:0] word_d;

    assign req     = rd_en | wr_en;
    assign in_xfer = (state_q == ST_LO) || (state_q == ST_HI);
    assign is_hi   = (state_q == ST_HI);
    // Byte offset from the data segment base; the low two bits select a byte and are dropped.
    assign word_d  = 17'((address - DATA_BASE) >> 2);

    sram_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (!in_xfer),
        .en_i    (in_xfer),
        .last_o  (phase_last)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = !req;
                if (req) state_d = ST_LO;
            end
            ST_LO:   if (phase_last) state_d = ST_HI;
            ST_HI:   if (phase_last) state_d = ST_DONE;
            // The request is still held high here (pipeline frozen); always go back to
            // IDLE so the next instruction's request is the one sampled.
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req) begin
                // A simultaneous read and write request is treated as a write.
                is_wr_q <= wr_en;
                word_q  <= word_d;
                wdata_q <= write_data;
            end
            if (in_xfer && phase_last && !is_wr_q) begin
                if (is_hi) rdata_q[31:16] <= SRAM_DQ;
                else       rdata_q[15:0]  <= SRAM_DQ;
            end
        end
    end

    assign read_data = rdata_q;
    assign SRAM_ADDR = in_xfer ? {word_q, is_hi} : '0;
    assign SRAM_CE_N = !in_xfer;
    assign SRAM_UB_N = !in_xfer;
    assign SRAM_LB_N = !in_xfer;
    assign SRAM_WE_N = !(in_xfer && is_wr_q);
    assign SRAM_OE_N = !(in_xfer && !is_wr_q);
    assign SRAM_DQ   = (in_xfer && is_wr_q) ? (is_hi ? wdata_q[31:16] : wdata_q[15:0])
                                            : 16'bz;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Purpose: randomized scoreboard bench for sram_mem_controller with a delayed-read SRAM model.
// Latency: checks 2*WAIT_CYCLES+1 busy cycles per transfer.
// Backpressure: requests are held until ready, as the frozen pipeline would.
module tb_sram_mem_controller;

    localparam int W      = 3;
    localparam int RD_DLY = 2;   // cycles before the SRAM model drives valid read data

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    wire  [31:0] read_data;
    wire         ready;
    wire  [15:0] sram_dq;
    wire  [17:0] sram_addr;
    wire         we_n, ce_n, oe_n, ub_n, lb_n;

    sram_mem_controller #(.WAIT_CYCLES(W), .DATA_BASE(32'd1024)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    // Second instance exercising the WAIT_CYCLES=1 boundary.
    logic        rd1, wr1;
    logic [31:0] addr1, wd1;
    wire  [31:0] rdata1;
    wire         ready1;
    wire  [15:0] dq1;
    wire  [17:0] sa1;
    wire         we1_n, ce1_n, oe1_n, ub1_n, lb1_n;

    sram_mem_controller #(.WAIT_CYCLES(1), .DATA_BASE(32'd1024)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
        .write_data(wd1), .read_data(rdata1), .ready(ready1),
        .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1_n), .SRAM_CE_N(ce1_n),
        .SRAM_OE_N(oe1_n), .SRAM_UB_N(ub1_n), .SRAM_LB_N(lb1_n)
    );

    // ---------------- SRAM models ----------------
    logic [15:0] sram  [0:4095];
    logic [15:0] sram1 [0:15];
    int          age;
    logic [17:0] age_addr;

    always @(negedge clk) begin
        if (!ce_n && !oe_n && sram_addr == age_addr) age <= age + 1;
        else                                         age <= 0;
        age_addr <= sram_addr;
    end
    assign sram_dq = (!ce_n && !oe_n && we_n)
                     ? ((age >= RD_DLY) ? sram[sram_addr[11:0]] : 16'h5A5A) : 16'bz;
    always @(posedge clk) if (!ce_n && !we_n) sram[sram_addr[11:0]] <= sram_dq;
    always @(posedge clk) if (!ce1_n && !we1_n) sram1[sa1[3:0]] <= dq1;

    // ---------------- checking ----------------
    int checks = 0, passes = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        bit          is_rd;
        logic [16:0] word;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [int];

    function automatic int hidx(logic [16:0] word, bit hi);
        return int'({word, hi});
    endfunction

    // Monitor: a completed transfer is a cycle with a request held and ready high
    // after one or more busy cycles.
    int low_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            low_cnt = 0;
        end else if (rd_en || wr_en) begin
            if (!ready) begin
                low_cnt++;
            end else if (low_cnt > 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("busy_cycles", low_cnt, e.lat);
                    if (e.is_rd) begin
                        check("read_data", read_data, e.data);
                    end else begin
                        check("sram_lo", {16'h0, sram[hidx(e.word, 1'b0)]}, {16'h0, e.data[15:0]});
                        check("sram_hi", {16'h0, sram[hidx(e.word, 1'b1)]}, {16'h0, e.data[31:16]});
                    end
                end
                low_cnt = 0;
            end
        end else begin
            low_cnt = 0;
        end
    end

    // Transfer-start tracker (CE_N falling).
    int   cyc = 0, starts = 0;
    int   start_cyc [2];
    logic ce_prev = 1'b1;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!ce_n && ce_prev) begin
            if (starts < 2) start_cyc[starts] = cyc;
            starts++;
        end
        ce_prev = ce_n;
    end

    function automatic exp_t mk_exp(bit rd, bit wr, logic [31:0] addr, logic [31:0] data);
        exp_t e;
        e.is_rd = rd && !wr;
        e.word  = 17'((addr - 32'd1024) >> 2);
        e.lat   = 2 * W + 1;
        if (wr) begin
            ref_mem[int'(e.word)] = data;
            e.data = data;
        end else begin
            e.data = ref_mem.exists(int'(e.word)) ? ref_mem[int'(e.word)] : 32'h0;
        end
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic do_op(bit rd, bit wr, logic [31:0] addr, logic [31:0] data);
        int n;
        sb.push_back(mk_exp(rd, wr, addr, data));
        rd_en = rd; wr_en = wr; address = addr; write_data = data;
        @(posedge clk); #1;
        // Once latched, the address/data inputs must no longer matter.
        address = $urandom; write_data = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 100);
        if (!ready) check("op_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        for (int i = 0; i < 4096; i++) sram[i] = 16'h0;
        for (int i = 0; i < 16; i++) sram1[i] = 16'h0;
        rst = 1'b0; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, ready}, 32'h1);
        check("rst_read_data", read_data, 32'h0);
        check("rst_we_n", {31'h0, we_n}, 32'h1);
        check("rst_ce_n", {31'h0, ce_n}, 32'h1);
        check("rst_oe_n", {31'h0, oe_n}, 32'h1);
        check("rst_addr", {14'h0, sram_addr}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic write / read-back, address map, write-wins on rd&wr.
        do_op(0, 1, 32'd1024, 32'hDEADBEEF);
        check("w0_lo", {16'h0, sram[0]}, 32'h0000BEEF);
        check("w0_hi", {16'h0, sram[1]}, 32'h0000DEAD);
        do_op(1, 0, 32'd1024, 32'h0);
        do_op(0, 1, 32'd1036, 32'h12345678);
        check("map_lo", {16'h0, sram[6]}, 32'h00005678);
        check("map_hi", {16'h0, sram[7]}, 32'h00001234);
        do_op(1, 0, 32'd1038, 32'h0);
        do_op(1, 1, 32'd1028, 32'hA5A50F0F);
        check("rw_lo", {16'h0, sram[2]}, 32'h00000F0F);
        check("rw_hi", {16'h0, sram[3]}, 32'h0000A5A5);

        // WAIT_CYCLES=1: busy in cycles 0..2, ready in cycle 3.
        rd1 = 1; wr1 = 1; addr1 = 32'd1028; wd1 = 32'hA5A50F0F;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("w1_ready_c%0d", k), {31'h0, ready1}, (k == 3) ? 32'h1 : 32'h0);
            if (k == 1) check("w1_oe_n", {31'h0, oe1_n}, 32'h1);
        end
        check("w1_lo", {16'h0, sram1[2]}, 32'h00000F0F);
        check("w1_hi", {16'h0, sram1[3]}, 32'h0000A5A5);
        @(posedge clk); #1;
        rd1 = 0; wr1 = 0;
        @(negedge clk);
        check("w1_rdata_kept", rdata1, 32'h0);
        @(posedge clk); #1;

        // Held read: exactly two transfers, one IDLE cycle apart.
        starts = 0;
        sb.push_back(mk_exp(1, 0, 32'd1024, 32'h0));
        sb.push_back(mk_exp(1, 0, 32'd1024, 32'h0));
        rd_en = 1; address = 32'd1024;
        repeat (16) @(posedge clk);
        #1 rd_en = 0;
        repeat (10) @(posedge clk);
        #1;
        check("held_starts", starts, 32'd2);
        check("held_spacing", start_cyc[1] - start_cyc[0], 2 * W + 2);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            a = 32'd1024 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            d = $urandom;
            case ($urandom_range(0, 2))
                0:       do_op(1, 0, a, d);
                1:       do_op(0, 1, a, d);
                default: do_op($urandom_range(0, 1) == 1, 1, a, d);
            endcase
        end

        // Reset mid-write: the high half must never be written.
        wr_en = 1; address = 32'd1024 + 32'd8000; write_data = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        check("mid_write_we_n", {31'h0, we_n}, 32'h0);
        #1 rst = 1'b0; wr_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mrst_ready", {31'h0, ready}, 32'h1);
        check("mrst_we_n", {31'h0, we_n}, 32'h1);
        check("mrst_ce_n", {31'h0, ce_n}, 32'h1);
        check("mrst_ub_lb", {30'h0, ub_n, lb_n}, 32'h3);
        check("mrst_hi_untouched", {16'h0, sram[4001]}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_hi_untouched", {16'h0, sram[4001]}, 32'h0);
        do_op(1, 0, 32'd1036, 32'h0);
        do_op(1, 0, 32'd1024 + ($urandom_range(0, 63) << 2), 32'h0);

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
